// File: rtl/dcache_pkg.sv
// Shared FSM type, address-field widths and line-address helper for dcache_ctrl.
// Optional hit/miss counters in dcache_ctrl are enabled by defining DCACHE_STATS_EN.
package dcache_pkg;

    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_MISS       = 3'd1,
        ST_WRITEBACK  = 3'd2,
        ST_ALLOCATE   = 3'd3,
        ST_ALLOC_DONE = 3'd4
    } dcache_state_t;

    function automatic int idx_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_width(input int addr_w, input int num_lines);
        return addr_w - OFFSET_W - $clog2(num_lines);
    endfunction

    // Rebuilds a line-aligned byte address from tag and index; callers truncate to ADDR_W.
    function automatic logic [63:0] line_addr(input logic [63:0] tag, input logic [63:0] idx,
                                              input int idx_w);
        return (tag << (OFFSET_W + idx_w)) | (idx << OFFSET_W);
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Line-wide memory bus between dcache_ctrl (master) and the backing memory (slave).
// Handshake: master raises mem_enable_o with address/data/direction held stable until the
// slave returns a one-cycle mem_ack_i; enable drops (or moves to the next transfer) the
// cycle after ack is sampled, and the slave must tolerate a request abandoned by reset.
interface dcache_if #(
    parameter int ADDR_W    = 32,
    parameter int LINE_BITS = 256
) ();
    logic                 mem_enable_o;
    logic                 mem_write_o;
    logic [ADDR_W-1:0]    mem_addr_o;
    logic [LINE_BITS-1:0] mem_data_o;
    logic [LINE_BITS-1:0] mem_data_i;
    logic                 mem_ack_i;

    modport master (
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );

    modport slave (
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );
endinterface

// File: rtl/dcache_sram.sv
// Tag, valid, dirty and data storage: combinational read port, one synchronous write port.
// A line write installs a fresh clean line; a word write stores the merged line and marks it dirty.
module dcache_sram #(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256,
    parameter int TAG_W     = 22,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_W-1:0]     i_idx,
    input  logic                 i_we_line,
    input  logic                 i_we_word,
    input  logic [TAG_W-1:0]     i_tag,
    input  logic [LINE_BITS-1:0] i_line,
    output logic                 o_valid,
    output logic                 o_dirty,
    output logic [TAG_W-1:0]     o_tag,
    output logic [LINE_BITS-1:0] o_line
);
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_BITS-1:0] r_data [NUM_LINES];

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_line  = r_data[i_idx];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_we_line) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_we_word) begin
            r_dirty[i_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (i_we_line) begin
            r_tag[i_idx]  <= i_tag;
            r_data[i_idx] <= i_line;
        end else if (i_we_word) begin
            r_data[i_idx] <= i_line;
        end
    end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate L1 data cache controller with line-wide fills.
// Defining DCACHE_STATS_EN adds wrapping 32-bit hit_cnt_o / miss_cnt_o counters.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p1_req_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    dcache_if.master          mem,
`ifdef DCACHE_STATS_EN
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
`endif
    output dcache_state_t     dbg_state_o
);
    localparam int IDX_W = idx_width(NUM_LINES);
    localparam int TAG_W = tag_width(ADDR_W, NUM_LINES);

    dcache_state_t r_state;
    dcache_state_t w_next;
    logic [IDX_W-1:0]      r_miss_idx;
    logic [TAG_W-1:0]      r_miss_tag;

    logic [IDX_W-1:0]      w_req_idx;
    logic [TAG_W-1:0]      w_req_tag;
    logic [WORD_SEL_W-1:0] w_word_sel;
    logic                  w_unused_addr;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_valid;
    logic                  w_dirty;
    logic [TAG_W-1:0]      w_tag;
    logic [LINE_BITS-1:0]  w_line;
    logic [LINE_BITS-1:0]  w_merged;
    logic [LINE_BITS-1:0]  w_wr_line;
    logic                  w_hit;
    logic                  w_lookup;
    logic                  w_hit_req;
    logic                  w_miss_req;
    logic                  w_we_word;
    logic                  w_we_line;

    assign w_req_idx     = p1_addr_i[OFFSET_W +: IDX_W];
    assign w_req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign w_word_sel    = p1_addr_i[OFFSET_W-1 -: WORD_SEL_W];
    assign w_unused_addr = ^p1_addr_i[1:0];

    // Outside IDLE the array is addressed by the latched miss, so a CPU that drops or
    // changes its request cannot disturb the victim line or the fill target.
    assign w_idx      = (r_state == ST_IDLE) ? w_req_idx : r_miss_idx;
    assign w_hit      = w_valid && (w_tag == w_req_tag);
    assign w_lookup   = (r_state == ST_IDLE) && p1_req_i;
    assign w_hit_req  = w_lookup && w_hit;
    assign w_miss_req = w_lookup && !w_hit;
    assign w_we_word  = w_hit_req && p1_write_i;
    assign w_we_line  = (r_state == ST_ALLOCATE) && mem.mem_ack_i;
    assign w_wr_line  = w_we_line ? mem.mem_data_i : w_merged;

    always_comb begin
        w_merged = w_line;
        w_merged[{w_word_sel, 5'd0} +: 32] = p1_data_i;
    end

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .LINE_BITS (LINE_BITS),
        .TAG_W     (TAG_W),
        .IDX_W     (IDX_W)
    ) u_sram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_idx     (w_idx),
        .i_we_line (w_we_line),
        .i_we_word (w_we_word),
        .i_tag     (r_miss_tag),
        .i_line    (w_wr_line),
        .o_valid   (w_valid),
        .o_dirty   (w_dirty),
        .o_tag     (w_tag),
        .o_line    (w_line)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_miss_idx <= '0;
            r_miss_tag <= '0;
        end else begin
            r_state <= w_next;
            if (w_miss_req) begin
                r_miss_idx <= w_req_idx;
                r_miss_tag <= w_req_tag;
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        p1_stall_o       = 1'b0;
        p1_data_o        = '0;
        mem.mem_enable_o = 1'b0;
        mem.mem_write_o  = 1'b0;
        mem.mem_addr_o   = '0;
        mem.mem_data_o   = '0;
        case (r_state)
            ST_IDLE: begin
                if (p1_req_i) begin
                    if (w_hit) begin
                        if (!p1_write_i) p1_data_o = w_line[{w_word_sel, 5'd0} +: 32];
                    end else begin
                        p1_stall_o = 1'b1;
                        w_next     = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                p1_stall_o = 1'b1;
                w_next     = w_dirty ? ST_WRITEBACK : ST_ALLOCATE;
            end
            ST_WRITEBACK: begin
                p1_stall_o       = 1'b1;
                mem.mem_enable_o = 1'b1;
                mem.mem_write_o  = 1'b1;
                mem.mem_addr_o   = ADDR_W'(line_addr(64'(w_tag), 64'(r_miss_idx), IDX_W));
                mem.mem_data_o   = w_line;
                if (mem.mem_ack_i) w_next = ST_ALLOCATE;
            end
            ST_ALLOCATE: begin
                p1_stall_o       = 1'b1;
                mem.mem_enable_o = 1'b1;
                mem.mem_addr_o   = ADDR_W'(line_addr(64'(r_miss_tag), 64'(r_miss_idx), IDX_W));
                if (mem.mem_ack_i) w_next = ST_ALLOC_DONE;
            end
            ST_ALLOC_DONE: begin
                p1_stall_o = 1'b1;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        // A held request misses against the freshly cleared valid bits during reset.
        if (rst_i) p1_stall_o = 1'b0;
    end

    assign dbg_state_o = r_state;

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_req)  r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_miss_req) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, multi-cycle corner sequences,
// and random accesses checked against a flat-memory reference with a tag directory.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam int NUM_LINES = 32;

    typedef struct packed {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_stall;
        logic [31:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic p1_req = 1'b0;
    logic p1_write = 1'b0;
    logic [31:0] p1_addr = '0;
    logic [31:0] p1_data = '0;
    logic [31:0] p1_data_o;
    logic        p1_stall_o;
    dcache_state_t dbg_state;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dcache_if #(.ADDR_W(32), .LINE_BITS(256)) mem_bus ();

    dcache_ctrl #(.NUM_LINES(NUM_LINES), .LINE_BITS(256), .ADDR_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .p1_req_i    (p1_req),
        .p1_write_i  (p1_write),
        .p1_addr_i   (p1_addr),
        .p1_data_i   (p1_data),
        .p1_data_o   (p1_data_o),
        .p1_stall_o  (p1_stall_o),
        .mem         (mem_bus),
`ifdef DCACHE_STATS_EN
        .hit_cnt_o   (hit_cnt),
        .miss_cnt_o  (miss_cnt),
`endif
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ---------------- backing memory model ----------------
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    logic [255:0] mem_store [int unsigned];
    txn_t txn_log[$];
    int rd_delay = 2;
    int wr_delay = 2;
    int proto_err = 0;
    int mem_cnt = 0;
    logic [31:0]  hold_addr = '0;
    logic         hold_write = 1'b0;
    logic [255:0] hold_data = '0;

    function automatic logic [255:0] mem_read_line(input logic [31:0] la);
        logic [255:0] l;
        if (mem_store.exists(la >> 5)) return mem_store[la >> 5];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w * 4));
        return l;
    endfunction

    always @(negedge clk) begin
        logic was_ack;
        txn_t t;
        was_ack = mem_bus.mem_ack_i;
        mem_bus.mem_ack_i = 1'b0;
        if (was_ack && mem_bus.mem_enable_o && mem_bus.mem_write_o == hold_write &&
            mem_bus.mem_addr_o == hold_addr) proto_err++;
        if (was_ack || !mem_bus.mem_enable_o) mem_cnt = 0;
        if (mem_bus.mem_enable_o) begin
            if (mem_cnt == 0) begin
                hold_addr  = mem_bus.mem_addr_o;
                hold_write = mem_bus.mem_write_o;
                hold_data  = mem_bus.mem_data_o;
            end else if (mem_bus.mem_addr_o != hold_addr || mem_bus.mem_write_o != hold_write ||
                         (hold_write && mem_bus.mem_data_o != hold_data)) begin
                proto_err++;
            end
            mem_cnt++;
            if (mem_cnt == (hold_write ? wr_delay : rd_delay)) begin
                mem_bus.mem_ack_i = 1'b1;
                t.wr = hold_write;
                t.addr = hold_addr;
                t.data = hold_data;
                txn_log.push_back(t);
                if (hold_write) mem_store[hold_addr >> 5] = hold_data;
                else mem_bus.mem_data_i = mem_read_line(hold_addr);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] gold [logic [31:0]];
    logic        ref_valid [NUM_LINES];
    logic        ref_dirty [NUM_LINES];
    int unsigned ref_tag   [NUM_LINES];
    logic [32:0] exp_q[$];

    function automatic void model_clear();
        for (int i = 0; i < NUM_LINES; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
            ref_tag[i]   = 0;
        end
    endfunction

    function automatic void model_access(input logic wr, input logic [31:0] addr,
                                         input logic [31:0] wdata, input int rdl, input int wdl,
                                         output int e_stall, output logic [31:0] e_data);
        int idx;
        int unsigned tag;
        idx = int'((addr >> 5) % NUM_LINES);
        tag = addr >> 10;
        e_stall = 0;
        if (!(ref_valid[idx] && ref_tag[idx] == tag)) begin
            if (ref_valid[idx] && ref_dirty[idx]) begin
                e_stall += wdl;
                exp_q.push_back({1'b1, 32'((ref_tag[idx] << 10) | (idx << 5))});
            end
            e_stall += rdl + 3;
            exp_q.push_back({1'b0, addr & ~32'd31});
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tag;
            ref_dirty[idx] = 1'b0;
        end
        if (wr) begin
            ref_dirty[idx] = 1'b1;
            gold[addr] = wdata;
            e_data = '0;
        end else begin
            e_data = gold.exists(addr) ? gold[addr] : init_word(addr);
        end
    endfunction

    // ---------------- CPU driver ----------------
    task automatic cpu_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              output int stalls, output logic [31:0] rdata, output logic to);
        stalls = 0;
        to = 1'b0;
        @(negedge clk);
        p1_req = 1'b1;
        p1_write = wr;
        p1_addr = addr;
        p1_data = wdata;
        #1;
        while (p1_stall_o && !to) begin
            stalls++;
            @(negedge clk);
            #1;
            if (stalls > 100) to = 1'b1;
        end
        rdata = p1_data_o;
        @(posedge clk);
        #1;
        p1_req = 1'b0;
        p1_write = 1'b0;
    endtask

    task automatic run_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input int rdl, input int wdl, output int stalls, output logic [31:0] rdata);
        logic to;
        rd_delay = rdl;
        wr_delay = wdl;
        cpu_access(wr, addr, wdata, stalls, rdata, to);
        if (to) begin
            n_checks++;
            n_fail++;
            $display("FAIL access_timeout: addr %08h stalled %0d cycles, required release", addr, stalls);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        p1_req = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    vec_t vecs[7];

    initial begin
        int stalls, e_stall, base, k;
        logic [31:0] rdata, e_data;
        logic [32:0] e;
        txn_t t;

        vecs[0] = '{1'b0, 32'h0000_0040, 32'h0, 5, init_word(32'h40)};
        vecs[1] = '{1'b0, 32'h0000_0040, 32'h0, 0, init_word(32'h40)};
        vecs[2] = '{1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 0, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0044, 32'h0, 0, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 32'h0000_0440, 32'h0, 7, init_word(32'h440)};
        vecs[5] = '{1'b0, 32'h0000_0044, 32'h0, 5, 32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 32'h0000_0048, 32'h0, 0, init_word(32'h48)};
        model_clear();

        // reset values
        @(negedge clk);
        #1;
        chk_int("rst_stall", int'(p1_stall_o), 0);
        chk_int("rst_enable", int'(mem_bus.mem_enable_o), 0);
        chk_int("rst_write", int'(mem_bus.mem_write_o), 0);
        chk_vec("rst_mem_addr", 256'(mem_bus.mem_addr_o), '0);
        chk_vec("rst_mem_data", mem_bus.mem_data_o, '0);
        chk_vec("rst_p1_data", 256'(p1_data_o), '0);
        chk_int("rst_state", int'(dbg_state), int'(ST_IDLE));
        rst = 1'b0;

        // directed table, memory latency 2 both ways
        base = txn_log.size();
        foreach (vecs[i]) begin
            model_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 2, 2, e_stall, e_data);
            exp_q.delete();
            run_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 2, 2, stalls, rdata);
            chk_int($sformatf("vec%0d_stall", i), stalls, vecs[i].exp_stall);
            chk_vec($sformatf("vec%0d_data", i), 256'(rdata), 256'(vecs[i].exp_data));
        end
        chk_int("vec_txn_count", txn_log.size() - base, 4);
        if (txn_log.size() - base >= 4) begin
            chk_vec("vec_txn0", 256'({txn_log[base].wr, txn_log[base].addr}), 256'({1'b0, 32'h40}));
            t = txn_log[base + 1];
            chk_vec("vec_txn1_wb", 256'({t.wr, t.addr}), 256'({1'b1, 32'h40}));
            chk_vec("vec_txn1_word1", 256'(t.data[63:32]), 256'(32'hDEAD_BEEF));
            chk_vec("vec_txn1_word0", 256'(t.data[31:0]), 256'(init_word(32'h40)));
            chk_vec("vec_txn2", 256'({txn_log[base+2].wr, txn_log[base+2].addr}), 256'({1'b0, 32'h440}));
            chk_vec("vec_txn3", 256'({txn_log[base+3].wr, txn_log[base+3].addr}), 256'({1'b0, 32'h40}));
        end

        // slow memory: ack after 10 enable cycles
        base = txn_log.size();
        model_access(1'b0, 32'h1080, 32'h0, 10, 2, e_stall, e_data);
        exp_q.delete();
        run_access(1'b0, 32'h1080, 32'h0, 10, 2, stalls, rdata);
        chk_int("slow_stall", stalls, 13);
        chk_vec("slow_data", 256'(rdata), 256'(init_word(32'h1080)));
        chk_int("slow_txn_count", txn_log.size() - base, 1);
        chk_int("slow_protocol", proto_err, 0);

        // random accesses over 4 tags x 4 indices
        for (int n = 0; n < 150; n++) begin
            logic wr;
            logic [31:0] addr, wdata;
            int rdl, wdl;
            wr = 1'($urandom_range(0, 1));
            addr = 32'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) |
                       ($urandom_range(0, 7) << 2));
            wdata = $urandom;
            rdl = $urandom_range(1, 4);
            wdl = $urandom_range(1, 4);
            base = txn_log.size();
            exp_q.delete();
            model_access(wr, addr, wdata, rdl, wdl, e_stall, e_data);
            run_access(wr, addr, wdata, rdl, wdl, stalls, rdata);
            chk_int($sformatf("rnd%0d_stall@%08h", n, addr), stalls, e_stall);
            chk_vec($sformatf("rnd%0d_data@%08h", n, addr), 256'(rdata), 256'(e_data));
            chk_int($sformatf("rnd%0d_txn_count", n), txn_log.size() - base, exp_q.size());
            k = 0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (base + k < txn_log.size())
                    chk_vec($sformatf("rnd%0d_txn%0d", n, k),
                            256'({txn_log[base+k].wr, txn_log[base+k].addr}), 256'(e));
                k++;
            end
        end
        chk_int("rnd_protocol", proto_err, 0);

        // reset in the middle of a fill
        rd_delay = 20;
        @(negedge clk);
        p1_req = 1'b1;
        p1_write = 1'b0;
        p1_addr = 32'h2100;
        repeat (4) @(negedge clk);
        #1;
        chk_int("mid_fill_enable", int'(mem_bus.mem_enable_o), 1);
        chk_vec("mid_fill_addr", 256'(mem_bus.mem_addr_o), 256'(32'h2100));
        #2;
        rst = 1'b1;
        #1;
        chk_int("abort_enable", int'(mem_bus.mem_enable_o), 0);
        chk_int("abort_stall", int'(p1_stall_o), 0);
        chk_int("abort_state", int'(dbg_state), int'(ST_IDLE));
        @(negedge clk);
        p1_req = 1'b0;
        #1;
        rst = 1'b0;
        model_clear();
        base = txn_log.size();
        exp_q.delete();
        model_access(1'b0, 32'h2100, 32'h0, 2, 2, e_stall, e_data);
        run_access(1'b0, 32'h2100, 32'h0, 2, 2, stalls, rdata);
        chk_int("post_abort_stall", stalls, e_stall);
        chk_vec("post_abort_data", 256'(rdata), 256'(init_word(32'h2100)));
        chk_int("post_abort_txn_count", txn_log.size() - base, 1);

`ifdef DCACHE_STATS_EN
        do_reset();
        chk_int("stats_rst_hits", int'(hit_cnt), 0);
        chk_int("stats_rst_misses", int'(miss_cnt), 0);
        run_access(1'b0, 32'h3000, 32'h0, 2, 2, stalls, rdata);
        run_access(1'b0, 32'h3020, 32'h0, 2, 2, stalls, rdata);
        run_access(1'b0, 32'h3000, 32'h0, 2, 2, stalls, rdata);
        run_access(1'b0, 32'h3020, 32'h0, 2, 2, stalls, rdata);
        run_access(1'b0, 32'h3004, 32'h0, 2, 2, stalls, rdata);
        chk_int("stats_misses", int'(miss_cnt), 2);
        chk_int("stats_hits", int'(hit_cnt), 5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
